axis_stream_top: RTL and testbench

Self-contained AXI4-Stream loopback subsystem: a packet generator (master) emits one PACKET_LEN-beat packet per start request, a DEPTH-entry synchronous FIFO buffers it, and a checking sink (slave) consumes and verifies it. It is the integration/bring-up top for the team's AXI-Stream blocks. Status outputs expose sink progress and errors.

---
 rtl/axis_stream_top.sv | 197 +++++++++++++++++++
 tb/tb_axis_stream_top.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_top.sv
// -----------------------------------------------------------------------------
// axis_stream_top
//
// AXI4-Stream loopback bring-up block. A packet generator emits one
// PACKET_LEN-beat packet per accepted start request. The packet passes through
// a DEPTH-entry show-ahead FIFO into a checking sink, which verifies the beat
// sequence and reports progress and errors.
//
// Ports:
//   clk       in   single clock, all logic on the rising edge
//   reset_n   in   synchronous reset, ACTIVE HIGH despite its name
//   start     in   packet request, sampled on every edge
//   pkt_done  out  one-cycle pulse after the sink accepts a tlast beat
//   rx_count  out  beats accepted in the current packet (cleared after tlast)
//   err       out  sticky mismatch flag, cleared only by reset
// -----------------------------------------------------------------------------
module axis_stream_top #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PACKET_LEN = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        pkt_done,
    output logic [15:0] rx_count,
    output logic        err
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [15:0]      LAST_IDX = 16'(PACKET_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_SEND = 1'b1
    } m_state_e;

    // Master side (generator -> FIFO)
    m_state_e              m_state_q;
    logic [15:0]           m_idx_q;
    logic                  m_tvalid_q;
    logic                  m_tlast_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic                  m_tready_s;

    // FIFO storage and bookkeeping; each entry is {tlast, tdata}
    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      f_cnt_q;
    logic [CNT_W-1:0]      f_cnt_d;
    logic                  f_full_s;
    logic                  f_empty_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    // Slave side (FIFO -> sink)
    logic                  s_tvalid_s;
    logic                  s_tready_s;
    logic                  s_tlast_s;
    logic [DATA_WIDTH-1:0] s_tdata_s;

    // Sink state
    logic [15:0]           exp_q;
    logic [15:0]           rx_count_q;
    logic                  pkt_done_q;
    logic                  err_q;

    // Generator FSM with registered AXIS outputs; the beat index doubles as payload
    always_ff @(posedge clk) begin
        if (reset_n) begin
            m_state_q  <= M_IDLE;
            m_idx_q    <= 16'd0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            case (m_state_q)
                M_IDLE: begin
                    if (start) begin
                        m_state_q  <= M_SEND;
                        m_idx_q    <= 16'd0;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b0;
                        m_tdata_q  <= '0;
                    end
                end
                M_SEND: begin
                    // Outputs hold while stalled; only a handshake advances the beat.
                    if (m_tvalid_q && m_tready_s) begin
                        if (m_tlast_q) begin
                            m_state_q  <= M_IDLE;
                            m_idx_q    <= 16'd0;
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            m_tdata_q  <= '0;
                        end else begin
                            m_idx_q   <= m_idx_q + 16'd1;
                            m_tdata_q <= DATA_WIDTH'(m_idx_q + 16'd1);
                            m_tlast_q <= ((m_idx_q + 16'd1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    m_state_q  <= M_IDLE;
                    m_idx_q    <= 16'd0;
                    m_tvalid_q <= 1'b0;
                    m_tlast_q  <= 1'b0;
                    m_tdata_q  <= '0;
                end
            endcase
        end
    end

    // FIFO flags, handshakes and show-ahead head entry (zeroed while empty)
    always_comb begin
        f_full_s   = (f_cnt_q == FULL_CNT);
        f_empty_s  = (f_cnt_q == {CNT_W{1'b0}});
        m_tready_s = !f_full_s;
        s_tvalid_s = !f_empty_s;
        s_tready_s = 1'b1;
        wr_en_s    = m_tvalid_q && m_tready_s;
        rd_en_s    = s_tvalid_s && s_tready_s;
        if (f_empty_s) begin
            {s_tlast_s, s_tdata_s} = '0;
        end else begin
            {s_tlast_s, s_tdata_s} = mem_q[rd_ptr_q];
        end
    end

    // Occupancy next state; a simultaneous read and write leaves it unchanged
    always_comb begin
        f_cnt_d = f_cnt_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   f_cnt_d = f_cnt_q + CNT_W'(1);
            2'b01:   f_cnt_d = f_cnt_q - CNT_W'(1);
            default: f_cnt_d = f_cnt_q;
        endcase
    end

    // FIFO storage write; contents need no reset because the head is gated by empty
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {m_tlast_q, m_tdata_q};
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            f_cnt_q  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            f_cnt_q <= f_cnt_d;
        end
    end

    // Checking sink: compares each beat with the expected index and tlast position
    always_ff @(posedge clk) begin
        if (reset_n) begin
            exp_q      <= 16'd0;
            rx_count_q <= 16'd0;
            pkt_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            if (rd_en_s) begin
                if ((s_tdata_s != DATA_WIDTH'(exp_q)) || (s_tlast_s != (exp_q == LAST_IDX))) begin
                    err_q <= 1'b1;
                end
                // Resynchronise on the received tlast so one bad packet does not cascade.
                if (s_tlast_s) begin
                    exp_q      <= 16'd0;
                    rx_count_q <= 16'd0;
                    pkt_done_q <= 1'b1;
                end else begin
                    exp_q      <= exp_q + 16'd1;
                    rx_count_q <= rx_count_q + 16'd1;
                end
            end
        end
    end

    assign pkt_done = pkt_done_q;
    assign rx_count = rx_count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_axis_stream_top.sv
// -----------------------------------------------------------------------------
// tb_axis_stream_top
//
// Two instances: defaults (32-bit, DEPTH 8, 8 beats) and a narrow variant
// (16-bit, DEPTH 2, 16 beats). A packet-level reference model predicts
// pkt_done and rx_count from the edges on which start was accepted; a monitor
// compares both instances against it on every cycle. Directed sequences
// carry hand-computed literal expectations, then random start/reset traffic
// runs against the model.
// -----------------------------------------------------------------------------
module tb_axis_stream_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic        st0  = 1'b0;
    logic        st1  = 1'b0;
    logic        done0, done1, err0, err1;
    logic [15:0] rx0, rx1;

    axis_stream_top #(.DATA_WIDTH(32), .DEPTH(8), .PACKET_LEN(8)) dut0 (
        .clk(clk), .reset_n(rst0), .start(st0),
        .pkt_done(done0), .rx_count(rx0), .err(err0)
    );

    axis_stream_top #(.DATA_WIDTH(16), .DEPTH(2), .PACKET_LEN(16)) dut1 (
        .clk(clk), .reset_n(rst1), .start(st1),
        .pkt_done(done1), .rx_count(rx1), .err(err1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;                 // number of rising edges so far
    int LEN[2]     = '{8, 16};
    int DONE_AT[2] = '{9, 17};        // hand-computed: pkt_done visible after E0+LEN+1
    int mcnt[2]    = '{0, 0};         // master beats still to be handed over
    int s_cur[2]   = '{-1000, -1000}; // edge of the most recent accepted start
    int s_prev[2]  = '{-1000, -1000};
    int done_cnt[2] = '{0, 0};
    logic r_cap0, r_cap1, s_cap0, s_cap1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, t);
        end
    endtask

    // Beat k of a packet started at edge s is accepted by the sink at edge s+2+k.
    function automatic int exp_rx(input int i);
        int d;
        d = t - s_cur[i];
        if (d >= 2 && d <= LEN[i]) return d - 1;
        return 0;
    endfunction

    function automatic int exp_done(input int i);
        return ((t == s_cur[i] + LEN[i] + 1) || (t == s_prev[i] + LEN[i] + 1)) ? 1 : 0;
    endfunction

    task automatic model_step(input int i, input logic r, input logic s);
        if (r) begin
            mcnt[i]   = 0;
            s_cur[i]  = -1000;
            s_prev[i] = -1000;
        end else if (mcnt[i] > 0) begin
            mcnt[i] = mcnt[i] - 1;
        end else if (s) begin
            mcnt[i]   = LEN[i];
            s_prev[i] = s_cur[i];
            s_cur[i]  = t;
        end
    endtask

    // Monitor: capture inputs at the edge, advance the model, compare at the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            t      = t + 1;
            r_cap0 = rst0;
            r_cap1 = rst1;
            s_cap0 = st0;
            s_cap1 = st1;
            @(negedge clk);
            model_step(0, r_cap0, s_cap0);
            model_step(1, r_cap1, s_cap1);
            check("pkt_done0", done0, exp_done(0));
            check("rx_count0", rx0, exp_rx(0));
            check("err0", err0, 0);
            check("pkt_done1", done1, exp_done(1));
            check("rx_count1", rx1, exp_rx(1));
            check("err1", err1, 0);
            if (done0) done_cnt[0]++;
            if (done1) done_cnt[1]++;
        end
    end

    task automatic set_start(input int i, input logic v);
        if (i == 0) st0 = v;
        else        st1 = v;
    endtask

    function automatic longint dut_done(input int i);
        return (i == 0) ? longint'(done0) : longint'(done1);
    endfunction

    function automatic longint dut_rx(input int i);
        return (i == 0) ? longint'(rx0) : longint'(rx1);
    endfunction

    task automatic wait_until(input int edge_no);
        while (t < edge_no) @(negedge clk);
    endtask

    task automatic single_packet(input int i);
        int e0;
        int base;
        @(negedge clk);
        set_start(i, 1'b1);
        e0 = t + 1;
        @(negedge clk);
        set_start(i, 1'b0);
        base = done_cnt[i];
        wait_until(e0 + 5);
        check("lit_rx_mid", dut_rx(i), 4);
        wait_until(e0 + DONE_AT[i] - 1);
        check("lit_done_early", dut_done(i), 0);
        wait_until(e0 + DONE_AT[i]);
        check("lit_done_at", dut_done(i), 1);
        check("lit_rx_cleared", dut_rx(i), 0);
        wait_until(e0 + DONE_AT[i] + 1);
        check("lit_done_width", dut_done(i), 0);
        wait_until(e0 + DONE_AT[i] + 3);
        check("lit_done_count", done_cnt[i] - base, 1);
    endtask

    initial begin
        int e0;
        int base;

        // Reset held for two edges
        repeat (2) @(negedge clk);
        check("rst_rx0", rx0, 0);
        check("rst_done0", done0, 0);
        check("rst_err0", err0, 0);
        check("rst_m_tvalid0", dut0.m_tvalid_q, 0);
        check("rst_s_tvalid0", dut0.s_tvalid_s, 0);
        check("rst_m_tvalid1", dut1.m_tvalid_q, 0);
        check("rst_s_tvalid1", dut1.s_tvalid_s, 0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Single packets on both instances (the second wraps the DEPTH-2 pointers)
        single_packet(0);
        single_packet(1);

        // start held for 18 edges: packets start at E0 and E0+9; a third would need E0+18
        @(negedge clk);
        st0  = 1'b1;
        e0   = t + 1;
        base = done_cnt[0];
        repeat (18) @(negedge clk);
        st0 = 1'b0;
        wait_until(e0 + 24);
        check("lit_held_two_packets", done_cnt[0] - base, 2);

        // A start pulse during SEND is ignored
        @(negedge clk);
        st0  = 1'b1;
        e0   = t + 1;
        base = done_cnt[0];
        @(negedge clk);
        st0 = 1'b0;
        wait_until(e0 + 3);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        wait_until(e0 + 16);
        check("lit_ignored_start", done_cnt[0] - base, 1);

        // Reset after beat 3 has been accepted
        @(negedge clk);
        st0  = 1'b1;
        e0   = t + 1;
        base = done_cnt[0];
        @(negedge clk);
        st0 = 1'b0;
        wait_until(e0 + 5);
        check("lit_rx_before_reset", rx0, 4);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check("lit_rx_after_reset", rx0, 0);
        check("lit_fifo_empty_after_reset", dut0.f_cnt_q, 0);
        check("lit_m_tvalid_after_reset", dut0.m_tvalid_q, 0);
        wait_until(e0 + 14);
        check("lit_no_done_after_reset", done_cnt[0] - base, 0);
        single_packet(0);

        // Random start/reset traffic against the model
        repeat (1500) begin
            @(negedge clk);
            st0  = ($urandom_range(0, 3) == 0);
            st1  = ($urandom_range(0, 3) == 0);
            rst0 = ($urandom_range(0, 149) == 0);
            rst1 = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        st0  = 1'b0;
        st1  = 1'b0;
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (40) @(negedge clk);
        check("final_rx0", rx0, 0);
        check("final_rx1", rx1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
